// File: rtl/ram_arbiter_pkg.sv
// Shared encodings for the RAM arbiter: FSM states, owner codes and
// last-owner tags.
package ram_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE    = 2'd0,
    ARB_OWN_CPU = 2'd1,
    ARB_OWN_LDR = 2'd2,
    ARB_TURN    = 2'd3
  } arb_state_t;

  localparam logic [1:0] OWNER_NONE = 2'b00;
  localparam logic [1:0] OWNER_CPU  = 2'b01;
  localparam logic [1:0] OWNER_LDR  = 2'b10;

  localparam logic LAST_CPU = 1'b0;
  localparam logic LAST_LDR = 1'b1;

endpackage

// File: rtl/ram_arbiter.sv
// Round-robin owner of the single-port RAM shared by the CPU datapath and the
// loader/debug port, with a per-grant access limit and one-cycle turnaround.
module ram_arbiter
  import ram_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_HOLD   = 4
) (
  input  logic                  clk,
  input  logic                  reset_cycle,
  input  logic                  cpu_req,
  input  logic                  cpu_we,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_wdata,
  output logic                  cpu_gnt,
  output logic                  cpu_rvalid,
  input  logic                  ldr_req,
  input  logic                  ldr_we,
  input  logic [ADDR_WIDTH-1:0] ldr_addr,
  input  logic [DATA_WIDTH-1:0] ldr_wdata,
  output logic                  ldr_gnt,
  output logic                  ldr_rvalid,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic                  ram_we,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  input  logic [DATA_WIDTH-1:0] ram_rdata,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic [1:0]            owner
);

  localparam logic [3:0] HOLD_LIMIT = 4'(MAX_HOLD);

  arb_state_t state, state_next;
  logic [3:0] hold_cnt, hold_next, hold_inc;
  logic       last_owner, last_owner_next;
  logic       cpu_access, ldr_access;
  logic       cpu_rd_p1, ldr_rd_p1;

  assign cpu_access = cpu_gnt & cpu_req;
  assign ldr_access = ldr_gnt & ldr_req;
  assign hold_inc   = hold_cnt + 4'd1;

  always_comb begin
    state_next      = state;
    hold_next       = hold_cnt;
    last_owner_next = last_owner;
    case (state)
      ARB_IDLE: begin
        // On contention the requester that did not own the RAM last wins
        if (cpu_req && (!ldr_req || last_owner == LAST_LDR)) begin
          state_next = ARB_OWN_CPU;
          hold_next  = 4'd0;
        end else if (ldr_req) begin
          state_next = ARB_OWN_LDR;
          hold_next  = 4'd0;
        end
      end
      ARB_OWN_CPU: begin
        last_owner_next = LAST_CPU;
        if (!cpu_req) begin
          state_next = ARB_IDLE;
        end else if (hold_inc >= HOLD_LIMIT) begin
          hold_next = 4'd0;
          if (ldr_req) state_next = ARB_TURN;
        end else begin
          hold_next = hold_inc;
        end
      end
      ARB_OWN_LDR: begin
        last_owner_next = LAST_LDR;
        if (!ldr_req) begin
          state_next = ARB_IDLE;
        end else if (hold_inc >= HOLD_LIMIT) begin
          hold_next = 4'd0;
          if (cpu_req) state_next = ARB_TURN;
        end else begin
          hold_next = hold_inc;
        end
      end
      ARB_TURN: begin
        hold_next  = 4'd0;
        state_next = (last_owner == LAST_LDR) ? ARB_OWN_CPU : ARB_OWN_LDR;
      end
      default: state_next = ARB_IDLE;
    endcase
  end

  // p0 -> p1: grant/state update and read-return tracking
  always_ff @(posedge clk or posedge reset_cycle) begin
    if (reset_cycle) begin
      state      <= ARB_IDLE;
      hold_cnt   <= 4'd0;
      last_owner <= LAST_LDR;
      cpu_gnt    <= 1'b0;
      ldr_gnt    <= 1'b0;
      cpu_rd_p1  <= 1'b0;
      ldr_rd_p1  <= 1'b0;
    end else begin
      state      <= state_next;
      hold_cnt   <= hold_next;
      last_owner <= last_owner_next;
      cpu_gnt    <= (state_next == ARB_OWN_CPU);
      ldr_gnt    <= (state_next == ARB_OWN_LDR);
      cpu_rd_p1  <= cpu_access & ~cpu_we;
      ldr_rd_p1  <= ldr_access & ~ldr_we;
    end
  end

  assign cpu_rvalid = cpu_rd_p1;
  assign ldr_rvalid = ldr_rd_p1;
  assign rdata      = ram_rdata;

  always_comb begin
    ram_addr  = '0;
    ram_wdata = '0;
    ram_we    = 1'b0;
    owner     = OWNER_NONE;
    if (cpu_gnt) begin
      ram_addr  = cpu_addr;
      ram_wdata = cpu_wdata;
      ram_we    = cpu_we & cpu_req;
      owner     = OWNER_CPU;
    end else if (ldr_gnt) begin
      ram_addr  = ldr_addr;
      ram_wdata = ldr_wdata;
      ram_we    = ldr_we & ldr_req;
      owner     = OWNER_LDR;
    end
  end

endmodule
